// File: rtl/qenc_home_sequencer.sv
// rtl/qenc_home_sequencer.sv - encoder homing handshake and motor sequencer
// Optional watchdog on the waiting states: define QENC_HOME_TIMEOUT_EN.
module qenc_home_sequencer #(
    parameter int WR_HOLD        = 3,
    parameter int SETTLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 16777216
) (
    input  logic        clk_i,
    input  logic        reset_n,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic        dir_i,
    input  logic [31:0] thresh_i,
    input  logic [31:0] enc_count_i,
    input  logic        enc_stop_motor_i,
    input  logic        enc_finished_i,
    output logic        enc_cr_wr_o,
    output logic        enc_calib_mode_o,
    output logic        enc_motor_stopped_o,
    output logic        enc_thresh_wr_o,
    output logic [31:0] enc_count_thresh_o,
    output logic        motor_en_o,
    output logic        motor_dir_o,
    output logic        motor_brake_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [1:0]  err_o
);

    localparam int HW = $clog2(WR_HOLD + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_SEEK, S_BRAKE, S_REPORT, S_WAIT_FIN, S_PROG, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [SW-1:0] stable_q, stable_d;
    logic [31:0] prev_count_q;
    logic        dir_q, dir_d;
    logic [31:0] thresh_q, thresh_d;
    logic        cr_wr_q, cr_wr_d, calib_mode_q, calib_mode_d;
    logic        motor_stopped_q, motor_stopped_d, thresh_wr_q, thresh_wr_d;
    logic [31:0] count_thresh_q, count_thresh_d;
    logic        motor_en_q, motor_en_d, motor_dir_q, motor_dir_d;
    logic        brake_q, brake_d, busy_q, busy_d, done_q, done_d;
    logic [1:0]  err_q, err_d;
    logic        tmo, kill, changed, hold_done;

`ifdef QENC_HOME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wd_q, wd_d;
    logic          wait_state;

    assign wait_state = state_q inside {S_SEEK, S_BRAKE, S_WAIT_FIN};
    assign tmo        = wait_state && (wd_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wd_d = wd_q;
        if (state_d != state_q) wd_d = '0;
        else if (wait_state)    wd_d = wd_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) wd_q <= '0;
        else          wd_q <= wd_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES[0];
    assign tmo = 1'b0;
`endif

    assign changed   = (enc_count_i != prev_count_q);
    assign hold_done = (hold_q == HW'(WR_HOLD - 1));
    assign kill      = (state_q != S_IDLE) && (abort_i || tmo);

    always_comb begin
        state_d  = state_q;
        stable_d = stable_q;
        dir_d    = dir_q;
        thresh_d = thresh_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: if (start_i) begin
                dir_d    = dir_i;
                thresh_d = thresh_i;
                err_d    = 2'd0;
                state_d  = S_ARM;
            end
            S_ARM:      if (hold_done) state_d = S_SEEK;
            S_SEEK:     if (enc_stop_motor_i) state_d = S_BRAKE;
            S_BRAKE: begin
                stable_d = changed ? '0 : stable_q + 1'b1;
                if (stable_d == SW'(SETTLE_CYCLES)) state_d = S_REPORT;
            end
            S_REPORT:   if (hold_done) state_d = S_WAIT_FIN;
            S_WAIT_FIN: if (enc_finished_i) state_d = S_PROG;
            S_PROG:     if (hold_done) state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
        // Abort outranks timeout, and both outrank every normal transition.
        if (kill) begin
            state_d = S_IDLE;
            err_d   = abort_i ? 2'd2 : 2'd1;
        end
        if (state_d != state_q) begin
            hold_d   = '0;
            stable_d = '0;
        end else if (state_q inside {S_ARM, S_REPORT, S_PROG}) begin
            hold_d = hold_q + 1'b1;
        end else begin
            hold_d = hold_q;
        end

        // Outputs are registered images of the next state.
        cr_wr_d         = (state_d == S_ARM) || (state_d == S_REPORT);
        calib_mode_d    = (state_d == S_ARM);
        motor_stopped_d = (state_d == S_REPORT);
        thresh_wr_d     = (state_d == S_PROG);
        count_thresh_d  = (state_d == S_PROG) ? thresh_q : count_thresh_q;
        motor_en_d      = (state_d == S_SEEK);
        motor_dir_d     = (state_d == S_SEEK) && dir_q;
        busy_d          = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d          = (state_d == S_DONE);
        case (state_d)
            S_BRAKE, S_REPORT, S_WAIT_FIN, S_PROG: brake_d = 1'b1;
            S_IDLE:  brake_d = kill ? 1'b1 : brake_q;
            default: brake_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            hold_q          <= '0;
            stable_q        <= '0;
            prev_count_q    <= '0;
            dir_q           <= 1'b0;
            thresh_q        <= '0;
            cr_wr_q         <= 1'b0;
            calib_mode_q    <= 1'b0;
            motor_stopped_q <= 1'b0;
            thresh_wr_q     <= 1'b0;
            count_thresh_q  <= '0;
            motor_en_q      <= 1'b0;
            motor_dir_q     <= 1'b0;
            brake_q         <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 2'd0;
        end else begin
            state_q         <= state_d;
            hold_q          <= hold_d;
            stable_q        <= stable_d;
            prev_count_q    <= enc_count_i;
            dir_q           <= dir_d;
            thresh_q        <= thresh_d;
            cr_wr_q         <= cr_wr_d;
            calib_mode_q    <= calib_mode_d;
            motor_stopped_q <= motor_stopped_d;
            thresh_wr_q     <= thresh_wr_d;
            count_thresh_q  <= count_thresh_d;
            motor_en_q      <= motor_en_d;
            motor_dir_q     <= motor_dir_d;
            brake_q         <= brake_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            err_q           <= err_d;
        end
    end

    assign enc_cr_wr_o         = cr_wr_q;
    assign enc_calib_mode_o    = calib_mode_q;
    assign enc_motor_stopped_o = motor_stopped_q;
    assign enc_thresh_wr_o     = thresh_wr_q;
    assign enc_count_thresh_o  = count_thresh_q;
    assign motor_en_o          = motor_en_q;
    assign motor_dir_o         = motor_dir_q;
    assign motor_brake_o       = brake_q;
    assign busy_o              = busy_q;
    assign done_o              = done_q;
    assign err_o               = err_q;

endmodule
